spi_slave_word: RTL and testbench
=================================

SPI_SLAVE_WORD -- requirements
Module: spi_slave_word

Interface
REQ-001 Parameter WIDTH, default 8: bits per SPI word, legal range 2..32.
REQ-002 Parameter CPOL, default 0: SCK idle level; 0 = idle low, 1 = idle high.
REQ-003 Parameter CPHA, default 0: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-004 Parameter MSB_FIRST, default 1: 1 = MSB shifted first, 0 = LSB shifted first.
REQ-005 clk  in  1  system clock; all logic on posedge clk; one clock domain.
REQ-006 ar  in  1  reset, asynchronous, active-high.
REQ-007 sck  in  1  SPI master clock, asynchronous to clk.
REQ-008 cs_n  in  1  SPI chip select, active low, asynchronous.
REQ-009 mosi  in  1  SPI master-out data, asynchronous.
REQ-010 miso  out  1  SPI master-in data.
REQ-011 tx_data  in  WIDTH  next word to transmit.
REQ-012 tx_valid  in  1  tx_data valid.
REQ-013 tx_ready  out  1  holding register empty; transfer occurs when tx_valid && tx_ready.
REQ-014 rx_data  out  WIDTH  last complete received word.
REQ-015 rx_valid  out  1  one-cycle pulse marking a new rx_data.
REQ-016 tx_underrun  out  1  one-cycle pulse when a word starts with no holding data.
REQ-017 frame_abort  out  1  one-cycle pulse when cs_n rises with a partial word.
REQ-018 busy  out  1  high while synchronised cs_n is low.

Function
REQ-019 SCK and cs_n pass through 3-flop synchronisers and MOSI through a 2-flop synchroniser; edges are detected from stages 2 and 3.
REQ-020 Leading edge = rising if CPOL=0, else falling; trailing edge = the opposite edge.
REQ-021 Sample edge = leading if CPHA=0, else trailing; shift edge = the other edge.
REQ-022 States: IDLE (cs inactive) and ACTIVE; IDLE->ACTIVE on synchronised cs_n falling edge; ACTIVE->IDLE on synchronised cs_n rising edge.
REQ-023 In ACTIVE, each sample edge shifts synchronised MOSI into rx_shift in MSB_FIRST order and increments bit_ctr; bit_ctr wraps from WIDTH-1 to 0.
REQ-024 On the sample edge of bit WIDTH-1, rx_data loads the completed word and rx_valid is high on the next cycle only; consecutive words are delivered back-to-back.
REQ-025 Load event for CPHA=0: the cs_n falling-edge cycle, plus every shift edge with bit_ctr==0 after at least one word in the frame.
REQ-026 Load event for CPHA=1: every shift edge with bit_ctr==0.
REQ-027 At a load event, tx_shift takes the holding register and clears it if it is full; otherwise tx_shift takes 0 and tx_underrun pulses.
REQ-028 At a non-load shift edge, tx_shift shifts one position toward the output bit and fills with 0.
REQ-029 miso = tx_shift[WIDTH-1] if MSB_FIRST, else tx_shift[0], while ACTIVE; miso = 0 in IDLE.
REQ-030 tx_ready = holding register empty; a load event and a tx handshake in the same cycle feed the new tx_data straight into tx_shift, and the holding register stays empty.
REQ-031 The holding register persists across frames; one word may be preloaded while IDLE.
REQ-032 When cs_n rises with bit_ctr != 0: frame_abort pulses, the partial word is discarded (no rx_valid), and bit_ctr is cleared.
REQ-033 If cs_n rises and an SCK edge is detected in the same cycle, cs_n takes priority and the SCK edge is ignored.
REQ-034 SCK edges in IDLE are ignored.
REQ-035 Minimum clk frequency: 8x SCK.

Reset
REQ-036 While ar is high: all synchronisers, bit_ctr, rx_shift, tx_shift and the holding register are 0; state = IDLE; miso=0, rx_data=0, rx_valid=0, tx_underrun=0, frame_abort=0, busy=0, tx_ready=1.
REQ-037 If ar asserts mid-frame, the frame is lost; after ar deasserts, the block waits for a fresh cs_n falling edge (with cs_n seen high first) before entering ACTIVE.

Verification
REQ-038 Mode 0, WIDTH=8: preload 0xA5, master sends 0x3C -> master receives 0xA5; rx_data=0x3C with one rx_valid pulse; tx_ready high again after load.
REQ-039 Modes 1, 2, 3 with the same data -> identical results to REQ-038.
REQ-040 WIDTH=16, MSB_FIRST=0, two words in one frame, tx words 0x1234/0xBEEF supplied just in time -> both received LSB-first; rx_valid pulses twice; no tx_underrun.
REQ-041 No tx data loaded, 8-bit frame -> miso all 0 and tx_underrun pulses once at the load.
REQ-042 cs_n rises after 5 bits -> frame_abort pulse, no rx_valid; the next full frame of 0x81 is received correctly.
REQ-043 ar pulsed mid-word -> all outputs at reset values; the next frame completes normally.

Source files
------------

// File: rtl/spi_slave_word.sv
// SPI slave with one-word transmit holding register, parameterised word width,
// clock polarity/phase and bit order. All logic runs on clk; SPI pins are oversampled.
module spi_slave_word #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          CPOL      = 1'b0,
  parameter bit          CPHA      = 1'b0,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             ar,
  input  logic             sck,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             tx_underrun,
  output logic             frame_abort,
  output logic             busy
);

  localparam int unsigned CTR_W = $clog2(WIDTH);
  localparam logic [CTR_W-1:0] LAST_BIT = CTR_W'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_sck_s, r_cs_s;
  logic [1:0]       r_mosi_s;
  logic [CTR_W-1:0] r_bit_ctr, w_bit_ctr_nxt;
  logic [WIDTH-1:0] r_rx_shift, w_rx_shift_nxt;
  logic [WIDTH-1:0] r_tx_shift, w_tx_shift_nxt;
  logic [WIDTH-1:0] r_hold, w_hold_nxt;
  logic             r_hold_full, w_hold_full_nxt;
  logic             r_word_seen, w_word_seen_nxt;
  logic [WIDTH-1:0] r_rx_data, w_rx_data_nxt;
  logic             r_rx_valid, w_rx_valid_nxt;
  logic             r_underrun, w_underrun_nxt;
  logic             r_abort, w_abort_nxt;
  logic             r_miso, r_busy, r_tx_ready;
  logic             w_load;

  // Edges come from synchroniser stages 2 and 3; MOSI stage 2 lines up with them.
  logic w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall;
  logic w_lead, w_trail, w_sample_edge, w_shift_edge;
  logic w_mosi_s, w_tx_fire;
  logic [WIDTH-1:0] w_rx_shifted, w_tx_shifted;

  assign w_sck_rise    = r_sck_s[1] & ~r_sck_s[2];
  assign w_sck_fall    = ~r_sck_s[1] & r_sck_s[2];
  assign w_cs_rise     = r_cs_s[1] & ~r_cs_s[2];
  assign w_cs_fall     = ~r_cs_s[1] & r_cs_s[2];
  assign w_lead        = CPOL ? w_sck_fall : w_sck_rise;
  assign w_trail       = CPOL ? w_sck_rise : w_sck_fall;
  assign w_sample_edge = CPHA ? w_trail : w_lead;
  assign w_shift_edge  = CPHA ? w_lead : w_trail;
  assign w_mosi_s      = r_mosi_s[1];
  assign w_tx_fire     = tx_valid & r_tx_ready;

  assign w_rx_shifted = MSB_FIRST ? {r_rx_shift[WIDTH-2:0], w_mosi_s}
                                  : {w_mosi_s, r_rx_shift[WIDTH-1:1]};
  assign w_tx_shifted = MSB_FIRST ? {r_tx_shift[WIDTH-2:0], 1'b0}
                                  : {1'b0, r_tx_shift[WIDTH-1:1]};

  // Next-state and datapath; a cs_n rise masks any SCK edge in the same cycle.
  always_comb begin
    w_state_nxt     = r_state;
    w_bit_ctr_nxt   = r_bit_ctr;
    w_rx_shift_nxt  = r_rx_shift;
    w_tx_shift_nxt  = r_tx_shift;
    w_hold_nxt      = r_hold;
    w_hold_full_nxt = r_hold_full;
    w_word_seen_nxt = r_word_seen;
    w_rx_data_nxt   = r_rx_data;
    w_rx_valid_nxt  = 1'b0;
    w_underrun_nxt  = 1'b0;
    w_abort_nxt     = 1'b0;
    w_load          = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt     = S_ACTIVE;
          w_bit_ctr_nxt   = '0;
          w_word_seen_nxt = 1'b0;
          w_load          = !CPHA;
        end
      end
      S_ACTIVE: begin
        if (w_cs_rise) begin
          w_state_nxt   = S_IDLE;
          w_bit_ctr_nxt = '0;
          w_abort_nxt   = (r_bit_ctr != '0);
        end else if (w_sample_edge) begin
          w_rx_shift_nxt = w_rx_shifted;
          if (r_bit_ctr == LAST_BIT) begin
            w_rx_data_nxt   = w_rx_shifted;
            w_rx_valid_nxt  = 1'b1;
            w_bit_ctr_nxt   = '0;
            w_word_seen_nxt = 1'b1;
          end else begin
            w_bit_ctr_nxt = r_bit_ctr + CTR_W'(1);
          end
        end else if (w_shift_edge) begin
          if ((r_bit_ctr == '0) && (CPHA || r_word_seen)) begin
            w_load = 1'b1;
          end else begin
            w_tx_shift_nxt = w_tx_shifted;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // A handshake coinciding with a load bypasses the (empty) holding register.
    if (w_load) begin
      if (r_hold_full) begin
        w_tx_shift_nxt  = r_hold;
        w_hold_full_nxt = 1'b0;
      end else if (w_tx_fire) begin
        w_tx_shift_nxt = tx_data;
      end else begin
        w_tx_shift_nxt = '0;
        w_underrun_nxt = 1'b1;
      end
    end else if (w_tx_fire) begin
      w_hold_nxt      = tx_data;
      w_hold_full_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge ar) begin
    if (ar) begin
      r_sck_s     <= '0;
      r_cs_s      <= '0;
      r_mosi_s    <= '0;
      r_state     <= S_IDLE;
      r_bit_ctr   <= '0;
      r_rx_shift  <= '0;
      r_tx_shift  <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_word_seen <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_underrun  <= 1'b0;
      r_abort     <= 1'b0;
      r_miso      <= 1'b0;
      r_busy      <= 1'b0;
      r_tx_ready  <= 1'b1;
    end else begin
      r_sck_s     <= {r_sck_s[1:0], sck};
      r_cs_s      <= {r_cs_s[1:0], cs_n};
      r_mosi_s    <= {r_mosi_s[0], mosi};
      r_state     <= w_state_nxt;
      r_bit_ctr   <= w_bit_ctr_nxt;
      r_rx_shift  <= w_rx_shift_nxt;
      r_tx_shift  <= w_tx_shift_nxt;
      r_hold      <= w_hold_nxt;
      r_hold_full <= w_hold_full_nxt;
      r_word_seen <= w_word_seen_nxt;
      r_rx_data   <= w_rx_data_nxt;
      r_rx_valid  <= w_rx_valid_nxt;
      r_underrun  <= w_underrun_nxt;
      r_abort     <= w_abort_nxt;
      r_miso      <= (w_state_nxt == S_ACTIVE) &&
                     (MSB_FIRST ? w_tx_shift_nxt[WIDTH-1] : w_tx_shift_nxt[0]);
      r_busy      <= (w_state_nxt == S_ACTIVE);
      r_tx_ready  <= ~w_hold_full_nxt;
    end
  end

  assign miso        = r_miso;
  assign busy        = r_busy;
  assign tx_ready    = r_tx_ready;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign tx_underrun = r_underrun;
  assign frame_abort = r_abort;

endmodule

// File: tb/tb_spi_slave_word.sv
// Bench for spi_slave_word: five instances covering SPI modes 0-3 (8-bit MSB-first)
// and a 16-bit LSB-first mode-1 slave, driven by a bit-level SPI master task.
module tb_spi_slave_word;

  localparam int unsigned H = 8;  // SCK half period in clk cycles

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        ar;
  logic [4:0]  sck_v, cs_n_v, mosi_v, txv;
  logic [15:0] txd;
  wire  [4:0]  miso_v, tx_ready_v, rx_valid_v, ur_v, ab_v, busy_v;
  wire  [7:0]  rxd0, rxd1, rxd2, rxd3;
  wire  [15:0] rxd4;

  spi_slave_word #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) u_m0 (
    .clk(clk), .ar(ar), .sck(sck_v[0]), .cs_n(cs_n_v[0]), .mosi(mosi_v[0]), .miso(miso_v[0]),
    .tx_data(txd[7:0]), .tx_valid(txv[0]), .tx_ready(tx_ready_v[0]), .rx_data(rxd0),
    .rx_valid(rx_valid_v[0]), .tx_underrun(ur_v[0]), .frame_abort(ab_v[0]), .busy(busy_v[0]));
  spi_slave_word #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b1), .MSB_FIRST(1'b1)) u_m1 (
    .clk(clk), .ar(ar), .sck(sck_v[1]), .cs_n(cs_n_v[1]), .mosi(mosi_v[1]), .miso(miso_v[1]),
    .tx_data(txd[7:0]), .tx_valid(txv[1]), .tx_ready(tx_ready_v[1]), .rx_data(rxd1),
    .rx_valid(rx_valid_v[1]), .tx_underrun(ur_v[1]), .frame_abort(ab_v[1]), .busy(busy_v[1]));
  spi_slave_word #(.WIDTH(8), .CPOL(1'b1), .CPHA(1'b0), .MSB_FIRST(1'b1)) u_m2 (
    .clk(clk), .ar(ar), .sck(sck_v[2]), .cs_n(cs_n_v[2]), .mosi(mosi_v[2]), .miso(miso_v[2]),
    .tx_data(txd[7:0]), .tx_valid(txv[2]), .tx_ready(tx_ready_v[2]), .rx_data(rxd2),
    .rx_valid(rx_valid_v[2]), .tx_underrun(ur_v[2]), .frame_abort(ab_v[2]), .busy(busy_v[2]));
  spi_slave_word #(.WIDTH(8), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b1)) u_m3 (
    .clk(clk), .ar(ar), .sck(sck_v[3]), .cs_n(cs_n_v[3]), .mosi(mosi_v[3]), .miso(miso_v[3]),
    .tx_data(txd[7:0]), .tx_valid(txv[3]), .tx_ready(tx_ready_v[3]), .rx_data(rxd3),
    .rx_valid(rx_valid_v[3]), .tx_underrun(ur_v[3]), .frame_abort(ab_v[3]), .busy(busy_v[3]));
  spi_slave_word #(.WIDTH(16), .CPOL(1'b0), .CPHA(1'b1), .MSB_FIRST(1'b0)) u_w16 (
    .clk(clk), .ar(ar), .sck(sck_v[4]), .cs_n(cs_n_v[4]), .mosi(mosi_v[4]), .miso(miso_v[4]),
    .tx_data(txd), .tx_valid(txv[4]), .tx_ready(tx_ready_v[4]), .rx_data(rxd4),
    .rx_valid(rx_valid_v[4]), .tx_underrun(ur_v[4]), .frame_abort(ab_v[4]), .busy(busy_v[4]));

  int n_checks = 0;
  int n_pass   = 0;
  int n_rxv[5];
  int n_ur[5];
  int n_ab[5];
  logic [4:0]  prev_rxv;
  logic [31:0] exp_rx_q[$];

  function automatic bit cpol_of(input int k);
    return (k == 2) || (k == 3);
  endfunction

  function automatic bit cpha_of(input int k);
    return (k == 1) || (k == 3) || (k == 4);
  endfunction

  function automatic logic [31:0] get_rx(input int k);
    case (k)
      0:       return {24'd0, rxd0};
      1:       return {24'd0, rxd1};
      2:       return {24'd0, rxd2};
      3:       return {24'd0, rxd3};
      default: return {16'd0, rxd4};
    endcase
  endfunction

  // Word-level model: loads per frame and the underruns they cause.
  function automatic int model_loads(input bit cpha, input int nbits, input int w);
    if (cpha) return (nbits + w - 1) / w;  // one load as each word starts
    return 1 + nbits / w;                  // cs_n fall plus one after each complete word
  endfunction

  function automatic int model_underruns(input bit cpha, input int nbits, input int w,
                                         input int supplied);
    int l;
    l = model_loads(cpha, nbits, w);
    return (l > supplied) ? l - supplied : 0;
  endfunction

  function automatic logic bit_at(input int i, input int w, input bit msbf,
                                  input logic [31:0] mw0, input logic [31:0] mw1);
    int j;
    logic [31:0] s;
    j = i % w;
    s = (i < w) ? mw0 : mw1;
    return s[msbf ? (w - 1 - j) : j];
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_tx(input int k, input logic [15:0] d);
    int guard;
    guard = 0;
    txd = d;
    txv[k] = 1'b1;
    while (tx_ready_v[k] !== 1'b1 && guard < 200) begin
      cyc(1);
      guard++;
    end
    if (guard >= 200) begin
      n_checks++;
      $display("FAIL tx_handshake_inst%0d: tx_ready stayed 0, required 1", k);
    end
    cyc(1);
    txv[k] = 1'b0;
  endtask

  // Bit-level SPI master; captures MISO on the sample edge of the instance's mode.
  task automatic spi_xfer(input int k, input int w, input bit msbf, input logic [31:0] mw0,
                          input logic [31:0] mw1, input int nbits, input bit end_cs,
                          output logic [31:0] r0, output logic [31:0] r1);
    bit cpol, cpha;
    int p;
    cpol = cpol_of(k);
    cpha = cpha_of(k);
    r0 = '0;
    r1 = '0;
    cs_n_v[k] = 1'b0;
    if (!cpha) mosi_v[k] = bit_at(0, w, msbf, mw0, mw1);
    cyc(H);
    for (int i = 0; i < nbits; i++) begin
      p = msbf ? (w - 1 - (i % w)) : (i % w);
      if (!cpha) begin
        sck_v[k] = ~cpol;
        if (i < w) r0[p] = miso_v[k]; else r1[p] = miso_v[k];
        cyc(H);
        sck_v[k] = cpol;
        if (i + 1 < nbits) mosi_v[k] = bit_at(i + 1, w, msbf, mw0, mw1);
        cyc(H);
      end else begin
        sck_v[k] = ~cpol;
        mosi_v[k] = bit_at(i, w, msbf, mw0, mw1);
        cyc(H);
        sck_v[k] = cpol;
        if (i < w) r0[p] = miso_v[k]; else r1[p] = miso_v[k];
        cyc(H);
      end
    end
    if (end_cs) begin
      cs_n_v[k] = 1'b1;
      mosi_v[k] = 1'b0;
      cyc(H);
    end
  endtask

  // One frame: optional preload, optional late tx word, then model-based frame checks.
  task automatic scen(input string nm, input int k, input int w, input bit msbf,
                      input int npre, input logic [15:0] pre, input int late_at,
                      input logic [15:0] late, input logic [31:0] mw0, input logic [31:0] mw1,
                      input int nbits, output logic [31:0] r0, output logic [31:0] r1);
    int supplied;
    logic [31:0] lr0, lr1;
    n_rxv[k] = 0;
    n_ur[k]  = 0;
    n_ab[k]  = 0;
    exp_rx_q.delete();
    supplied = npre + ((late_at > 0) ? 1 : 0);
    if (nbits >= w)     exp_rx_q.push_back(mw0);
    if (nbits >= 2 * w) exp_rx_q.push_back(mw1);
    if (npre > 0) push_tx(k, pre);
    fork
      spi_xfer(k, w, msbf, mw0, mw1, nbits, 1'b1, lr0, lr1);
      begin
        if (late_at > 0) begin
          cyc(late_at);
          push_tx(k, late);
        end
      end
    join
    r0 = lr0;
    r1 = lr1;
    cyc(12);
    chk({nm, " rx_valid count"}, 32'(n_rxv[k]), 32'(nbits / w));
    chk({nm, " tx_underrun count"}, 32'(n_ur[k]),
        32'(model_underruns(cpha_of(k), nbits, w, supplied)));
    chk({nm, " frame_abort count"}, 32'(n_ab[k]), 32'(((nbits % w) != 0) ? 1 : 0));
    chk({nm, " rx words outstanding"}, 32'(exp_rx_q.size()), 32'd0);
    chk({nm, " tx_ready"}, 32'(tx_ready_v[k]), 32'd1);
    chk({nm, " busy after cs_n high"}, 32'(busy_v[k]), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("%s miso inst%0d", tag, k), 32'(miso_v[k]), 32'd0);
      chk($sformatf("%s rx_data inst%0d", tag, k), get_rx(k), 32'd0);
      chk($sformatf("%s rx_valid inst%0d", tag, k), 32'(rx_valid_v[k]), 32'd0);
      chk($sformatf("%s tx_underrun inst%0d", tag, k), 32'(ur_v[k]), 32'd0);
      chk($sformatf("%s frame_abort inst%0d", tag, k), 32'(ab_v[k]), 32'd0);
      chk($sformatf("%s busy inst%0d", tag, k), 32'(busy_v[k]), 32'd0);
      chk($sformatf("%s tx_ready inst%0d", tag, k), 32'(tx_ready_v[k]), 32'd1);
    end
  endtask

  // Per-cycle compare: received words in order, single-cycle rx_valid, miso low when idle.
  always @(negedge clk) begin
    if (ar !== 1'b0) begin
      prev_rxv = '0;
    end else begin
      for (int k = 0; k < 5; k++) begin
        if (rx_valid_v[k]) begin
          n_rxv[k]++;
          chk($sformatf("rx_valid width inst%0d", k), 32'(prev_rxv[k]), 32'd0);
          if (exp_rx_q.size() == 0) begin
            n_checks++;
            $display("FAIL rx_unexpected inst%0d: got word 0x%0h, expected no word", k,
                     get_rx(k));
          end else begin
            chk($sformatf("rx_data inst%0d", k), get_rx(k), exp_rx_q.pop_front());
          end
        end
        if (ur_v[k]) n_ur[k]++;
        if (ab_v[k]) n_ab[k]++;
        if (!busy_v[k]) chk($sformatf("miso idle inst%0d", k), 32'(miso_v[k]), 32'd0);
      end
      prev_rxv = rx_valid_v;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not reach its end, required completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] r0, r1;
    ar     = 1'b1;
    sck_v  = 5'b01100;
    cs_n_v = '1;
    mosi_v = '0;
    txv    = '0;
    txd    = '0;
    for (int k = 0; k < 5; k++) begin
      n_rxv[k] = 0;
      n_ur[k]  = 0;
      n_ab[k]  = 0;
    end
    cyc(3);
    check_reset_outputs("reset");
    ar = 1'b0;
    cyc(10);

    // Same exchange in all four modes: slave sends 0xA5, master sends 0x3C.
    for (int k = 0; k < 4; k++) begin
      scen($sformatf("mode%0d", k), k, 8, 1'b1, 1, 16'h00A5, 0, 16'h0, 32'h3C, 32'h0, 8, r0, r1);
      chk($sformatf("mode%0d master rx", k), r0, 32'hA5);
    end
    chk("mode0 underrun literal", 32'(n_ur[0]), 32'd1);
    chk("mode1 underrun literal", 32'(n_ur[1]), 32'd0);

    // 16-bit LSB-first, two words, second tx word supplied mid-frame.
    scen("w16", 4, 16, 1'b0, 1, 16'h1234, 60, 16'hBEEF, 32'h5AF0, 32'h0001, 32, r0, r1);
    chk("w16 master word0", r0, 32'h1234);
    chk("w16 master word1", r1, 32'hBEEF);
    chk("w16 underrun literal", 32'(n_ur[4]), 32'd0);

    // Nothing to send: zeros on MISO and a single underrun.
    scen("no_tx", 1, 8, 1'b1, 0, 16'h0, 0, 16'h0, 32'h55, 32'h0, 8, r0, r1);
    chk("no_tx master rx", r0, 32'h00);
    chk("no_tx underrun literal", 32'(n_ur[1]), 32'd1);

    // Partial frame of 5 bits, then a clean frame.
    scen("abort", 0, 8, 1'b1, 0, 16'h0, 0, 16'h0, 32'hB7, 32'h0, 5, r0, r1);
    chk("abort pulse literal", 32'(n_ab[0]), 32'd1);
    chk("abort rx_valid literal", 32'(n_rxv[0]), 32'd0);
    scen("after_abort", 0, 8, 1'b1, 1, 16'h007E, 0, 16'h0, 32'h81, 32'h0, 8, r0, r1);
    chk("after_abort master rx", r0, 32'h7E);
    chk("after_abort rx_data literal", get_rx(0), 32'h81);

    // Reset in the middle of a word with cs_n held low.
    push_tx(0, 16'h003C);
    push_tx(2, 16'h0011);
    exp_rx_q.delete();
    spi_xfer(0, 8, 1'b1, 32'hF0, 32'h0, 3, 1'b0, r0, r1);
    ar = 1'b1;
    cyc(2);
    check_reset_outputs("mid_reset");
    ar = 1'b0;
    cyc(20);
    chk("post_reset stays idle with cs_n low", 32'(busy_v[0]), 32'd0);
    cs_n_v[0] = 1'b1;
    cyc(10);
    chk("post_reset still idle after cs_n high", 32'(busy_v[0]), 32'd0);
    scen("after_reset", 0, 8, 1'b1, 1, 16'h005A, 0, 16'h0, 32'h99, 32'h0, 8, r0, r1);
    chk("after_reset master rx", r0, 32'h5A);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
